// File: rtl/traffic_phase_scheduler.sv
// Traffic phase scheduler: two-direction signalised intersection with
// pedestrian walk phase and emergency-vehicle preemption. All timing is
// counted in ticks; lamp outputs are decoded from the registered state.
module traffic_phase_scheduler #(
  parameter int GREEN_MIN   = 5,
  parameter int YELLOW_TIME = 2,
  parameter int ALLRED_TIME = 1,
  parameter int WALK_TIME   = 4,
  parameter int CNT_W       = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       ns_req,
  input  logic       ew_req,
  input  logic       ped_req,
  input  logic       emerg_req,
  input  logic       emerg_dir,
  output logic       ns_g,
  output logic       ns_y,
  output logic       ew_g,
  output logic       ew_y,
  output logic       walk,
  output logic [2:0] phase,
  output logic       ped_ack,
  output logic       emerg_active
);

  typedef enum logic [2:0] {
    NS_G  = 3'd0,
    NS_Y  = 3'd1,
    RED_A = 3'd2,
    EW_G  = 3'd3,
    EW_Y  = 3'd4,
    RED_B = 3'd5,
    WALK  = 3'd6,
    EMRG  = 3'd7
  } state_t;

  localparam logic [CNT_W-1:0] GREEN_LAST  = CNT_W'(GREEN_MIN - 1);
  localparam logic [CNT_W-1:0] YELLOW_LAST = CNT_W'(YELLOW_TIME - 1);
  localparam logic [CNT_W-1:0] ALLRED_LAST = CNT_W'(ALLRED_TIME - 1);
  localparam logic [CNT_W-1:0] WALK_LAST   = CNT_W'(WALK_TIME - 1);

  state_t           state_q, state_d;
  state_t           redNext;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ns_p_q, ns_p_d;
  logic             ew_p_q, ew_p_d;
  logic             ped_p_q, ped_p_d;
  logic             last_dir_q, last_dir_d;
  logic             edir_q, edir_d;
  logic             ped_ack_q, ped_ack_d;

  // Destination when an all-red interval expires: emergency, then walk, then alternate greens
  always_comb begin
    redNext = NS_G;
    if (emerg_req) begin
      redNext = EMRG;
    end else if (ped_p_q) begin
      redNext = WALK;
    end else if (last_dir_q) begin
      redNext = NS_G;
    end else begin
      redNext = EW_G;
    end
  end

  // Phase transitions; preemption moves are immediate, timed moves wait for tick
  always_comb begin
    state_d = state_q;
    case (state_q)
      NS_G: begin
        if (emerg_req && emerg_dir) begin
          state_d = NS_Y;
        end else if (emerg_req) begin
          state_d = EMRG;
        end else if (tick && (cnt_q >= GREEN_LAST) && (ew_p_q || ped_p_q)) begin
          state_d = NS_Y;
        end
      end
      EW_G: begin
        if (emerg_req && !emerg_dir) begin
          state_d = EW_Y;
        end else if (emerg_req) begin
          state_d = EMRG;
        end else if (tick && (cnt_q >= GREEN_LAST) && (ns_p_q || ped_p_q)) begin
          state_d = EW_Y;
        end
      end
      NS_Y: if (tick && (cnt_q == YELLOW_LAST)) state_d = RED_A;
      EW_Y: if (tick && (cnt_q == YELLOW_LAST)) state_d = RED_B;
      RED_A, RED_B: if (tick && (cnt_q == ALLRED_LAST)) state_d = redNext;
      WALK: begin
        if (emerg_req || (tick && (cnt_q == WALK_LAST))) state_d = RED_B;
      end
      EMRG: if (!emerg_req) state_d = edir_q ? EW_Y : NS_Y;
      default: state_d = NS_G;
    endcase
  end

  // Counter, pending requests and entry-latched registers; clearing on entry beats a new pulse
  always_comb begin
    cnt_d      = cnt_q;
    ns_p_d     = ns_p_q | ns_req;
    ew_p_d     = ew_p_q | ew_req;
    ped_p_d    = ped_p_q | ped_req;
    last_dir_d = last_dir_q;
    edir_d     = edir_q;
    ped_ack_d  = 1'b0;
    if (state_d != state_q) begin
      cnt_d = '0;
      case (state_d)
        NS_G: begin
          ns_p_d     = 1'b0;
          last_dir_d = 1'b0;
        end
        EW_G: begin
          ew_p_d     = 1'b0;
          last_dir_d = 1'b1;
        end
        WALK: begin
          ped_p_d   = 1'b0;
          ped_ack_d = 1'b1;
        end
        EMRG:    edir_d = emerg_dir;
        default: ;
      endcase
    end else if (tick && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // State registers with synchronous reset into NS green
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= NS_G;
      cnt_q      <= '0;
      ns_p_q     <= 1'b0;
      ew_p_q     <= 1'b0;
      ped_p_q    <= 1'b0;
      last_dir_q <= 1'b0;
      edir_q     <= 1'b0;
      ped_ack_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      ns_p_q     <= ns_p_d;
      ew_p_q     <= ew_p_d;
      ped_p_q    <= ped_p_d;
      last_dir_q <= last_dir_d;
      edir_q     <= edir_d;
      ped_ack_q  <= ped_ack_d;
    end
  end

  // Lamp decode from registered state only, so greens and walk are mutually exclusive
  always_comb begin
    ns_g         = (state_q == NS_G) || ((state_q == EMRG) && !edir_q);
    ns_y         = (state_q == NS_Y);
    ew_g         = (state_q == EW_G) || ((state_q == EMRG) && edir_q);
    ew_y         = (state_q == EW_Y);
    walk         = (state_q == WALK);
    phase        = state_q;
    ped_ack      = ped_ack_q;
    emerg_active = (state_q == EMRG);
  end

endmodule
